// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants used by the
// transmitter and the existing uart_receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
// Pointers carry one extra MSB so that full and empty can be told apart.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_ptr_nxt;
   logic [AW:0]      rd_ptr_nxt;
   logic             do_wr;
   logic             do_rd;

   assign do_wr      = wr_en && !full;
   assign do_rd      = rd_en && !empty;
   assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_wr};
   assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_rd};
   assign dout       = mem[rd_ptr[AW-1:0]];

   // Flags are computed from next-state pointers so they are true registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         empty  <= (wr_ptr_nxt == rd_ptr_nxt);
         full   <= (wr_ptr_nxt == {~rd_ptr_nxt[AW], rd_ptr_nxt[AW-1:0]});
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are framed
// back-to-back onto a registered serial line.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       serial_out,
   output logic       tx_idle
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

   uart_state_e      state;
   logic [CNT_W-1:0] sym_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             push_armed;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_dout;
   logic             push;
   logic             pop;
   logic             last_sym;

   assign data_in_ready = !fifo_full;
   assign push          = data_in_valid && data_in_ready && push_armed;
   assign last_sym      = (sym_cnt == CNT_W'(SYMBOL_EDGE_TIME - 1));
   assign pop           = !fifo_empty && ((state == IDLE) || (state == STOP && last_sym));
   assign tx_idle       = (state == IDLE) && fifo_empty;

   fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (push),
      .din   (data_in),
      .full  (fifo_full),
      .rd_en (pop),
      .dout  (fifo_dout),
      .empty (fifo_empty)
   );

   // Pushes are ignored on the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         push_armed <= 1'b0;
      end else begin
         push_armed <= 1'b1;
      end
   end

   // serial_out is registered from the current state, so the line lags the
   // state by one cycle: the start bit appears one edge after the pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sym_cnt    <= '0;
         bit_idx    <= '0;
         serial_out <= STOP_BIT;
      end else begin
         case (state)
            IDLE: begin
               serial_out <= STOP_BIT;
               sym_cnt    <= '0;
               if (pop) begin
                  state <= START;
               end
            end
            START: begin
               serial_out <= START_BIT;
               if (last_sym) begin
                  sym_cnt <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
               end else begin
                  sym_cnt <= sym_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               serial_out <= shift_reg[0];
               if (last_sym) begin
                  sym_cnt <= '0;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  sym_cnt <= sym_cnt + CNT_W'(1);
               end
            end
            STOP: begin
               serial_out <= STOP_BIT;
               if (last_sym) begin
                  sym_cnt <= '0;
                  state   <= fifo_empty ? IDLE : START;
               end else begin
                  sym_cnt <= sym_cnt + CNT_W'(1);
               end
            end
            default: begin
               state      <= IDLE;
               serial_out <= STOP_BIT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         shift_reg <= fifo_dout;
      end else if (state == DATA && last_sym) begin
         shift_reg <= {1'b0, shift_reg[7:1]};
      end
   end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning the serial bit rate in bits/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the byte buffer depth; it is a power of two and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port data_in, input, 8 bits: the byte to transmit.
REQ-007 SHALL have port data_in_valid, input, 1 bit: producer offers data_in.
REQ-008 SHALL have port data_in_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-009 SHALL have port serial_out, output, 1 bit: UART line; idle level is high.
REQ-010 SHALL have port tx_idle, output, 1 bit: high when the FIFO is empty and no frame is in progress.

Function
REQ-011 SHALL accept a byte on every rising edge where data_in_valid and data_in_ready are both high; it never accepts one otherwise.
REQ-012 SHALL drive data_in_ready = !fifo_full, a registered flag that does not depend on data_in_valid.
REQ-013 SHALL hold SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division) clk cycles per bit, counted by a counter of width clog2(SYMBOL_EDGE_TIME).
REQ-014 SHALL send each frame as exactly 10 symbols: start 0, data[0]..data[7] LSB first, then stop 1.
REQ-015 SHALL use the FSM states IDLE, START, DATA, STOP.
REQ-016 SHALL step from IDLE to START when the FIFO is not empty: pop one byte into the shift register and drive serial_out low from the next edge.
REQ-017 SHALL step from START to DATA, and from DATA to STOP, after SYMBOL_EDGE_TIME cycles; DATA steps only after 8 symbols, tracked by a 3-bit bit index.
REQ-018 SHALL, on the last cycle of STOP, go directly to START (popping the next byte) if the FIFO is not empty, otherwise to IDLE.
REQ-019 SHALL send back-to-back bytes with no idle gap between frames.
REQ-020 SHALL drive serial_out from a register, never glitching, and high in IDLE and STOP.
REQ-021 SHALL have no FIFO bypass: with the FIFO empty and idle, a byte accepted at edge N makes serial_out low from edge N+2.
REQ-022 SHALL, on a simultaneous push and pop, succeed in both and leave the occupancy unchanged.
REQ-023 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, with full/empty told apart by an extra pointer MSB.
REQ-024 SHALL keep a frame in progress unaffected by pushes, including the FIFO becoming full.
REQ-025 SHALL drive tx_idle as a combinational function of the state and FIFO empty.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force: state IDLE, FIFO empty, pointers 0, counters 0, serial_out 1, data_in_ready 1, tx_idle 1.
REQ-027 SHALL, on reset asserted mid-frame, abort the frame immediately, with serial_out high within the same cycle, and lose the buffered bytes.
REQ-028 SHALL accept no byte on the first rising edge after rst_n deasserts; data_in_ready is permitted high but the push is ignored.

Structure
REQ-029 SHALL place the FSM state enum and the frame constants (START_BIT=0, STOP_BIT=1, FRAME_BITS=10) in the shared package uart_pkg, reused by the existing uart_receiver.
REQ-030 SHALL instantiate the FIFO as a sub-module named fifo (WIDTH=8, DEPTH=FIFO_DEPTH), with ports wr_en, din, full, rd_en, dout, empty.

Verification (CLOCK_FREQ=50_000_000, BAUD_RATE=10_000_000 -> 5 cycles/bit, 50 cycles/frame)
REQ-031 SHALL cover: push 0x41 while idle -> serial_out low at N+2, line decodes 0x41 ("A"), tx_idle high again 50 cycles after the start bit.
REQ-032 SHALL cover: push "Result: " (8 bytes) back-to-back -> 400 contiguous cycles of frames, no gap, correct byte order.
REQ-033 SHALL cover: FIFO_DEPTH=8 with valid held high -> ready drops after 9 accepts (8 buffered + 1 popped), then rises one cycle after the next pop.
REQ-034 SHALL cover: push and pop on the same edge with the FIFO at 3 entries -> occupancy stays 3, no byte lost or duplicated.
REQ-035 SHALL cover: reset asserted during bit 4 of 0xA5 -> serial_out 1 at once, tx_idle 1, and no further transitions until a new push.
REQ-036 SHALL cover: 0x00 and 0xFF frames -> start, stop and data levels exact per symbol, sampled at mid-bit (cycle 2 of 5).
